// File: rtl/lcd_sprite_engine.sv
// KS0108-style dual-chip 128x64 GLCD sprite driver.
// Powers the panel up, clears it, then paints clipped sprites fetched from an
// external combinational pattern ROM, splitting rows across the two chip halves.
// Optional feature macro: LCD_SPRITE_INVERT_EN (adds i_cmd_inv, inverts sprite bytes).
module lcd_sprite_engine #(
  parameter int SPR_W      = 8,
  parameter int SPR_PAGES  = 1,
  parameter int NUM_SPR    = 4,
  parameter int GAP_CYCLES = 4,
  localparam int SPR_SEL_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
  localparam int IDX_W     = (SPR_W * SPR_PAGES > 1) ? $clog2(SPR_W * SPR_PAGES) : 1
) (
  input  logic                       i_lcd_clk,
  input  logic                       i_reset,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic                       i_cmd_clear,
  input  logic [2:0]                 i_cmd_page,
  input  logic [6:0]                 i_cmd_col,
  input  logic [SPR_SEL_W-1:0]       i_cmd_spr,
`ifdef LCD_SPRITE_INVERT_EN
  input  logic                       i_cmd_inv,
`endif
  output logic [SPR_SEL_W+IDX_W-1:0] o_rom_addr,
  input  logic [7:0]                 i_rom_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [7:0]                 o_lcd_data,
  output logic                       o_lcd_di,
  output logic                       o_lcd_rw,
  output logic                       o_lcd_cs1,
  output logic                       o_lcd_cs2,
  output logic                       o_lcd_enable,
  output logic                       o_lcd_rstn
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [6:0]       C_LAST = 7'(SPR_W - 1);
  localparam logic [3:0]       P_LAST = 4'(SPR_PAGES - 1);
  localparam logic [GAP_W-1:0] G_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT_ON, S_INIT_SL, S_CLEAR, S_IDLE, S_SET_PAGE, S_SET_COL, S_WRITE, S_GAP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [2:0]            r_page_base;
  logic [6:0]            r_col_base;
  logic [SPR_SEL_W-1:0]  r_spr;
  logic                  r_clear_cmd;
  logic [3:0]            r_p;          // page offset within the sprite
  logic [6:0]            r_c;          // column offset within the sprite
  logic [2:0]            r_clr_page;
  logic [6:0]            r_clr_step;   // 0: set page, 1: set column, 2..65: zero bytes
  logic [GAP_W-1:0]      r_gap;
  logic [7:0]            r_lcd_data;
  logic                  r_lcd_di;
  logic                  r_cs1;
  logic                  r_cs2;
  logic                  r_en;
  logic                  r_ready;
  logic                  r_done;

  logic                  w_txn;
  logic [7:0]            w_data;
  logic                  w_di;
  logic                  w_cs1;
  logic                  w_cs2;
  logic                  w_accept;
  logic [3:0]            w_page_abs;
  logic [7:0]            w_col_abs;
  logic [7:0]            w_col_nxt;
  logic                  w_row_last;
  logic                  w_pg_last;
  logic [IDX_W-1:0]      w_idx;
  logic [7:0]            w_byte;

`ifdef LCD_SPRITE_INVERT_EN
  logic                  r_inv;
  assign w_byte = r_inv ? ~i_rom_data : i_rom_data;
`else
  assign w_byte = i_rom_data;
`endif

  // Eight-bit column arithmetic so that column 127 + 1 is seen as off-screen.
  assign w_page_abs = {1'b0, r_page_base} + r_p;
  assign w_col_abs  = {1'b0, r_col_base} + {1'b0, r_c};
  assign w_col_nxt  = w_col_abs + 8'd1;
  assign w_row_last = (r_c == C_LAST) || w_col_nxt[7];
  assign w_pg_last  = (r_p == P_LAST) || (w_page_abs == 4'd7);
  assign w_idx      = IDX_W'(32'(r_p) * 32'(SPR_W) + 32'(r_c));
  assign w_accept   = (r_state == S_IDLE) && r_ready && i_cmd_valid;

  assign o_rom_addr   = {r_spr, w_idx};
  assign o_cmd_ready  = r_ready;
  assign o_busy       = ~r_ready;
  assign o_done       = r_done;
  assign o_lcd_data   = r_lcd_data;
  assign o_lcd_di     = r_lcd_di;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_cs1    = r_cs1;
  assign o_lcd_cs2    = r_cs2;
  assign o_lcd_enable = i_lcd_clk & r_en;
  assign o_lcd_rstn   = ~i_reset;

  // Next state and the bus transaction to launch on the coming edge.
  always_comb begin
    w_state_next = r_state;
    w_txn        = 1'b0;
    w_data       = r_lcd_data;
    w_di         = r_lcd_di;
    w_cs1        = r_cs1;
    w_cs2        = r_cs2;
    case (r_state)
      S_INIT_ON: begin
        w_txn = 1'b1; w_data = 8'h3F; w_di = 1'b0; w_cs1 = 1'b1; w_cs2 = 1'b1;
        w_state_next = S_INIT_SL;
      end
      S_INIT_SL: begin
        w_txn = 1'b1; w_data = 8'hC0; w_di = 1'b0; w_cs1 = 1'b1; w_cs2 = 1'b1;
        w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_txn = 1'b1; w_cs1 = 1'b1; w_cs2 = 1'b1;
        if (r_clr_step == 7'd0) begin
          w_data = 8'hB8 | {5'd0, r_clr_page}; w_di = 1'b0;
        end else if (r_clr_step == 7'd1) begin
          w_data = 8'h40; w_di = 1'b0;
        end else begin
          w_data = 8'h00; w_di = 1'b1;
        end
        if (r_clr_page == 3'd7 && r_clr_step == 7'd65)
          w_state_next = r_clear_cmd ? S_GAP : S_IDLE;
      end
      S_IDLE: begin
        if (w_accept) w_state_next = i_cmd_clear ? S_CLEAR : S_SET_PAGE;
      end
      S_SET_PAGE: begin
        w_txn = 1'b1; w_data = 8'hB8 | {5'd0, w_page_abs[2:0]}; w_di = 1'b0;
        w_cs1 = ~w_col_abs[6]; w_cs2 = w_col_abs[6];
        w_state_next = S_SET_COL;
      end
      S_SET_COL: begin
        w_txn = 1'b1; w_data = 8'h40 | {2'd0, w_col_abs[5:0]}; w_di = 1'b0;
        w_cs1 = ~w_col_abs[6]; w_cs2 = w_col_abs[6];
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_txn = 1'b1; w_data = w_byte; w_di = 1'b1;
        w_cs1 = ~w_col_abs[6]; w_cs2 = w_col_abs[6];
        if (w_row_last)              w_state_next = w_pg_last ? S_GAP : S_SET_PAGE;
        else if (w_col_nxt == 8'd64) w_state_next = S_SET_PAGE;
        else                         w_state_next = S_WRITE;
      end
      S_GAP: begin
        if (r_gap == G_LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_INIT_ON;
    endcase
  end

  // State register and registered LCD bus / handshake outputs.
  always_ff @(posedge i_lcd_clk) begin
    if (i_reset) begin
      r_state    <= S_INIT_ON;
      r_lcd_data <= 8'h00;
      r_lcd_di   <= 1'b0;
      r_cs1      <= 1'b1;
      r_cs2      <= 1'b1;
      r_en       <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_lcd_data <= w_data;
      r_lcd_di   <= w_di;
      r_cs1      <= w_cs1;
      r_cs2      <= w_cs2;
      r_en       <= w_txn;
      r_ready    <= (r_state == S_IDLE) && (w_state_next == S_IDLE);
      r_done     <= (r_state == S_GAP) && (r_gap == '0);
    end
  end

  // Command latch and the page/column/clear/gap counters.
  always_ff @(posedge i_lcd_clk) begin
    if (i_reset) begin
      r_page_base <= 3'd0;
      r_col_base  <= 7'd0;
      r_spr       <= '0;
      r_clear_cmd <= 1'b0;
      r_p         <= 4'd0;
      r_c         <= 7'd0;
      r_clr_page  <= 3'd0;
      r_clr_step  <= 7'd0;
      r_gap       <= '0;
`ifdef LCD_SPRITE_INVERT_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_page_base <= i_cmd_page;
          r_col_base  <= i_cmd_col;
          r_spr       <= i_cmd_spr;
          r_clear_cmd <= i_cmd_clear;
          r_p         <= 4'd0;
          r_c         <= 7'd0;
          r_clr_page  <= 3'd0;
          r_clr_step  <= 7'd0;
          r_gap       <= '0;
`ifdef LCD_SPRITE_INVERT_EN
          r_inv       <= i_cmd_inv;
`endif
        end
        S_CLEAR: begin
          if (r_clr_step == 7'd65) begin
            r_clr_step <= 7'd0;
            r_clr_page <= r_clr_page + 3'd1;
          end else begin
            r_clr_step <= r_clr_step + 7'd1;
          end
        end
        S_WRITE: begin
          if (w_row_last) begin
            r_c <= 7'd0;
            r_p <= r_p + 4'd1;
          end else begin
            r_c <= r_c + 7'd1;
          end
        end
        S_GAP: r_gap <= r_gap + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sprite_engine.sv
// Bench for lcd_sprite_engine: captures every LCD bus transaction and compares
// against transaction lists built from the panel's drawing rules.
module tb_lcd_sprite_engine;

  localparam int SPR_W = 8, SPR_PAGES = 2, NUM_SPR = 4, GAP = 4;
  localparam int AW = 6;   // 2 sprite-select bits + 4 index bits

  typedef struct packed {
    logic       cs1;
    logic       cs2;
    logic       di;
    logic [7:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_clear, cmd_inv;
  logic [2:0]    cmd_page;
  logic [6:0]    cmd_col;
  logic [1:0]    cmd_spr;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          busy, done;
  logic [7:0]    lcd_data;
  logic          lcd_di, lcd_rw, lcd_cs1, lcd_cs2, lcd_enable, lcd_rstn;

  logic [7:0] rom_mem [0:(1<<AW)-1];
  assign rom_data = rom_mem[rom_addr];

  always #5 clk = ~clk;

  lcd_sprite_engine #(
    .SPR_W(SPR_W), .SPR_PAGES(SPR_PAGES), .NUM_SPR(NUM_SPR), .GAP_CYCLES(GAP)
  ) dut (
    .i_lcd_clk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_clear(cmd_clear),
    .i_cmd_page(cmd_page), .i_cmd_col(cmd_col), .i_cmd_spr(cmd_spr),
`ifdef LCD_SPRITE_INVERT_EN
    .i_cmd_inv(cmd_inv),
`endif
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_busy(busy), .o_done(done),
    .o_lcd_data(lcd_data), .o_lcd_di(lcd_di), .o_lcd_rw(lcd_rw),
    .o_lcd_cs1(lcd_cs1), .o_lcd_cs2(lcd_cs2),
    .o_lcd_enable(lcd_enable), .o_lcd_rstn(lcd_rstn)
  );

  txn_t cap_q[$];
  int   cap_cyc[$];
  txn_t exp_q[$];
  int   cyc = 0, done_cnt = 0, done_cyc = 0, ready_cyc = 0, rw_bad = 0;
  logic prev_ready = 1'b0;
  int   errors = 0, checks = 0;

  // Bus monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (lcd_enable === 1'b1) begin
      cap_q.push_back({lcd_cs1, lcd_cs2, lcd_di, lcd_data});
      cap_cyc.push_back(cyc);
      if (lcd_rw !== 1'b0) rw_bad++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cmd_ready === 1'b1 && prev_ready !== 1'b1) ready_cyc = cyc;
    prev_ready = cmd_ready;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic cs1, input logic cs2, input logic di, input logic [7:0] d);
    return {cs1, cs2, di, d};
  endfunction

  function automatic void build_clear();
    for (int pg = 0; pg < 8; pg++) begin
      exp_q.push_back(mk(1, 1, 0, 8'hB8 | 8'(pg)));
      exp_q.push_back(mk(1, 1, 0, 8'h40));
      for (int b = 0; b < 64; b++) exp_q.push_back(mk(1, 1, 1, 8'h00));
    end
  endfunction

  function automatic void build_init();
    exp_q.delete();
    exp_q.push_back(mk(1, 1, 0, 8'h3F));
    exp_q.push_back(mk(1, 1, 0, 8'hC0));
    build_clear();
  endfunction

  // Expected draw: each visible page gets a header, a new header when crossing
  // into the right chip, and one byte per on-screen column.
  function automatic void build_draw(input int page, input int col, input int spr, input bit inv);
    int pg, x;
    bit hdr;
    logic [7:0] b;
    exp_q.delete();
    for (int p = 0; p < SPR_PAGES; p++) begin
      pg = page + p;
      if (pg > 7) break;
      hdr = 1'b1;
      for (int c = 0; c < SPR_W; c++) begin
        x = col + c;
        if (x > 127) break;
        if (hdr || x == 64) begin
          exp_q.push_back(mk(x < 64, x >= 64, 0, 8'hB8 | 8'(pg)));
          exp_q.push_back(mk(x < 64, x >= 64, 0, 8'h40 | 8'(x % 64)));
          hdr = 1'b0;
        end
        b = rom_mem[spr * 16 + p * SPR_W + c];
        if (inv) b = ~b;
        exp_q.push_back(mk(x < 64, x >= 64, 1, b));
      end
    end
  endfunction

  task automatic compare_q(input string tag);
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_txn%0d", tag, i), cap_q[i], exp_q[i]);
      if (cap_q[i] !== exp_q[i]) break;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_ready_timeout"}, cmd_ready, 1);
  endtask

  task automatic run_cmd(input bit clr, input int page, input int col, input int spr,
                         input bit inv, input string tag);
    int last;
    wait_ready({tag, "_pre"});
    cap_q.delete(); cap_cyc.delete(); done_cnt = 0;
    cmd_clear = clr; cmd_page = 3'(page); cmd_col = 7'(col); cmd_spr = 2'(spr); cmd_inv = inv;
    cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    check({tag, "_ready_drop"}, cmd_ready, 0);
    check({tag, "_busy"}, busy, 1);
    wait_ready(tag);
    if (clr) begin
      exp_q.delete();
      build_clear();
    end else begin
      build_draw(page, col, spr, inv);
    end
    compare_q(tag);
    last = (cap_cyc.size() > 0) ? cap_cyc[$] : -1000;
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc, last + 1);
    check({tag, "_gap"}, ready_cyc, done_cyc + GAP);
    $display("cmd %s clr=%0d page=%0d col=%0d spr=%0d inv=%0d txns=%0d", tag, clr, page, col, spr,
             inv, cap_q.size());
  endtask

  initial begin
    int c0;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 8'($urandom_range(0, 255));
    reset = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_page = 3'd0; cmd_col = 7'd0;
    cmd_spr = 2'd0; cmd_inv = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_data", lcd_data, 8'h00);
    check("rst_di", lcd_di, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_cs1", lcd_cs1, 1);
    check("rst_cs2", lcd_cs2, 1);
    check("rst_enable", lcd_enable, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_rstn", lcd_rstn, 0);
    $display("reset values checked");

    // Power-up sequence and its length.
    cap_q.delete(); cap_cyc.delete();
    reset = 1'b0;
    wait_ready("init");
    build_init();
    compare_q("init");
    c0 = (cap_cyc.size() > 0) ? cap_cyc[0] : -1000;
    check("init_ready_cycle", ready_cyc - c0, 530);
    $display("init txns=%0d ready_after=%0d", cap_q.size(), ready_cyc - c0);

    // Directed draws: left chip, chip crossing, bottom-right clipping, crossing on two pages.
    run_cmd(0, 3, 16, 1, 0, "p3c16");
    run_cmd(0, 0, 60, 2, 0, "c60");
    run_cmd(0, 7, 124, 3, 0, "p7c124");
    run_cmd(0, 5, 62, 0, 0, "p5c62");
    run_cmd(0, 2, 64, 2, 0, "c64");

    // Randomized draws.
    for (int k = 0; k < 6; k++) begin
      bit inv_r;
`ifdef LCD_SPRITE_INVERT_EN
      inv_r = 1'($urandom_range(0, 1));
`else
      inv_r = 1'b0;
`endif
      run_cmd(0, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 3), inv_r,
              $sformatf("rnd%0d", k));
    end

`ifdef LCD_SPRITE_INVERT_EN
    rom_mem[16] = 8'h18;
    run_cmd(0, 2, 20, 1, 1, "inv");
    check("inv_byte", (cap_q.size() > 2) ? cap_q[2].data : 8'h00, 8'hE7);
    run_cmd(1, 0, 0, 0, 1, "clr_inv");
`endif

    // Whole-screen clear command.
    run_cmd(1, 5, 99, 3, 0, "clr");

    // Reset while the fifth sprite byte is being launched.
    wait_ready("rstmid_pre");
    cap_q.delete(); cap_cyc.delete();
    cmd_clear = 1'b0; cmd_page = 3'd1; cmd_col = 7'd10; cmd_spr = 2'd1; cmd_inv = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (cap_q.size() >= 6) break;
      @(posedge clk); #2;
    end
    check("rstmid_reach", cap_q.size(), 6);
    reset = 1'b1;
    @(posedge clk); #2;
    check("rstmid_enable", lcd_enable, 0);
    check("rstmid_cs1", lcd_cs1, 1);
    check("rstmid_cs2", lcd_cs2, 1);
    check("rstmid_data", lcd_data, 8'h00);
    check("rstmid_di", lcd_di, 0);
    check("rstmid_ready", cmd_ready, 0);
    check("rstmid_busy", busy, 1);
    check("rstmid_no5th", cap_q.size(), 6);
    @(posedge clk); #2;
    cap_q.delete(); cap_cyc.delete();
    reset = 1'b0;
    wait_ready("rstmid_restart");
    build_init();
    compare_q("rstmid_restart");
    $display("reset mid-draw restart txns=%0d", cap_q.size());

    check("rw_zero", rw_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
